// File: rtl/spi_responder.sv
// SPI responder endpoint: oversamples SCLK/CS_n/MOSI in the clkIn domain and
// shifts DATA_WIDTH-bit words MSB first, with a valid/ready transmit side.
module spi_responder #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clkIn,
    input  logic                  rstN,
    input  logic                  sclkIn,
    input  logic                  csNIn,
    input  logic                  mosiIn,
    output logic                  misoOut,
    output logic                  misoOe,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic                  txValid,
    output logic                  txReady,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    output logic                  txUnderrun,
    output logic                  busy
);

    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                state_r;
    logic [SYNC_N-1:0]     sclk_sync_r;
    logic [SYNC_N-1:0]     csn_sync_r;
    logic [SYNC_N-1:0]     mosi_sync_r;
    logic                  sclk_dly_r;
    logic                  csn_dly_r;
    logic [DATA_WIDTH-1:0] tx_shift_r;
    logic [DATA_WIDTH-1:0] rx_shift_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic                  first_lead_r;

    logic                  sclk_s;
    logic                  csn_s;
    logic                  mosi_s;
    logic                  sclk_rise_s;
    logic                  sclk_fall_s;
    logic                  lead_s;
    logic                  trail_s;
    logic                  sample_s;
    logic                  shift_s;
    logic                  csn_fall_s;
    logic                  csn_rise_s;
    logic                  word_done_s;
    logic [DATA_WIDTH-1:0] rx_next_s;
    logic [DATA_WIDTH-1:0] load_word_s;

    // Input synchronizers plus one history flop each for edge detection
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            sclk_sync_r <= {SYNC_N{CPOL}};
            csn_sync_r  <= {SYNC_N{1'b1}};
            mosi_sync_r <= {SYNC_N{1'b0}};
            sclk_dly_r  <= CPOL;
            csn_dly_r   <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_N-2:0], sclkIn};
            csn_sync_r  <= {csn_sync_r[SYNC_N-2:0], csNIn};
            mosi_sync_r <= {mosi_sync_r[SYNC_N-2:0], mosiIn};
            sclk_dly_r  <= sclk_sync_r[SYNC_N-1];
            csn_dly_r   <= csn_sync_r[SYNC_N-1];
        end
    end

    // Edge classification and next-word helpers
    always_comb begin
        sclk_s      = sclk_sync_r[SYNC_N-1];
        csn_s       = csn_sync_r[SYNC_N-1];
        mosi_s      = mosi_sync_r[SYNC_N-1];
        sclk_rise_s = sclk_s & ~sclk_dly_r;
        sclk_fall_s = ~sclk_s & sclk_dly_r;
        csn_fall_s  = ~csn_s & csn_dly_r;
        csn_rise_s  = csn_s & ~csn_dly_r;
        if (CPOL) begin
            lead_s  = sclk_fall_s;
            trail_s = sclk_rise_s;
        end else begin
            lead_s  = sclk_rise_s;
            trail_s = sclk_fall_s;
        end
        if (CPHA) begin
            sample_s = trail_s;
            shift_s  = lead_s;
        end else begin
            sample_s = lead_s;
            shift_s  = trail_s;
        end
        word_done_s = sample_s && (bit_cnt_r == LAST_CNT);
        rx_next_s   = {rx_shift_r[DATA_WIDTH-2:0], mosi_s};
        if (txValid) begin
            load_word_s = txData;
        end else begin
            load_word_s = ZERO_WORD;
        end
    end

    // Frame control, shift registers and registered fabric/pin outputs
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            state_r      <= ST_IDLE;
            tx_shift_r   <= ZERO_WORD;
            rx_shift_r   <= ZERO_WORD;
            bit_cnt_r    <= CNT_ZERO;
            first_lead_r <= 1'b1;
            misoOut      <= 1'b0;
            misoOe       <= 1'b0;
            txReady      <= 1'b0;
            rxData       <= ZERO_WORD;
            rxValid      <= 1'b0;
            txUnderrun   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            txReady    <= 1'b0;
            rxValid    <= 1'b0;
            txUnderrun <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    misoOe  <= 1'b0;
                    misoOut <= 1'b0;
                    busy    <= 1'b0;
                    if (csn_fall_s) begin
                        state_r      <= ST_ACTIVE;
                        busy         <= 1'b1;
                        misoOe       <= 1'b1;
                        bit_cnt_r    <= CNT_ZERO;
                        rx_shift_r   <= ZERO_WORD;
                        first_lead_r <= 1'b1;
                        tx_shift_r   <= load_word_s;
                        txReady      <= txValid;
                        txUnderrun   <= ~txValid;
                        // CPHA=1 drives the MSB only on the first leading edge
                        misoOut      <= (CPHA == 1'b0) ? load_word_s[DATA_WIDTH-1] : 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (word_done_s) begin
                        rxData     <= rx_next_s;
                        rxValid    <= 1'b1;
                        bit_cnt_r  <= CNT_ZERO;
                        rx_shift_r <= ZERO_WORD;
                        if (csn_rise_s) begin
                            state_r    <= ST_IDLE;
                            busy       <= 1'b0;
                            misoOe     <= 1'b0;
                            misoOut    <= 1'b0;
                            tx_shift_r <= ZERO_WORD;
                        end else begin
                            first_lead_r <= 1'b1;
                            tx_shift_r   <= load_word_s;
                            txReady      <= txValid;
                            txUnderrun   <= ~txValid;
                            misoOut      <= (CPHA == 1'b0) ? load_word_s[DATA_WIDTH-1] : misoOut;
                        end
                    end else if (csn_rise_s) begin
                        state_r    <= ST_IDLE;
                        busy       <= 1'b0;
                        misoOe     <= 1'b0;
                        misoOut    <= 1'b0;
                        bit_cnt_r  <= CNT_ZERO;
                        rx_shift_r <= ZERO_WORD;
                        tx_shift_r <= ZERO_WORD;
                    end else if (sample_s) begin
                        rx_shift_r <= rx_next_s;
                        bit_cnt_r  <= bit_cnt_r + CNT_ONE;
                    end else if (shift_s) begin
                        if (CPHA == 1'b0) begin
                            // bit_cnt 0 here means the word was just reloaded; keep its MSB
                            if (bit_cnt_r != CNT_ZERO) begin
                                tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                                misoOut    <= tx_shift_r[DATA_WIDTH-2];
                            end else begin
                                misoOut <= tx_shift_r[DATA_WIDTH-1];
                            end
                        end else if (first_lead_r) begin
                            misoOut      <= tx_shift_r[DATA_WIDTH-1];
                            first_lead_r <= 1'b0;
                        end else begin
                            tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                            misoOut    <= tx_shift_r[DATA_WIDTH-2];
                        end
                    end else begin
                        state_r <= ST_ACTIVE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    misoOe  <= 1'b0;
                    misoOut <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a mode-0 16-bit instance and a mode-3
// 8-bit instance driven by bit-banged SPI masters.
module tb_spi_responder;

    localparam int PH = 20;

    logic        clk;
    logic        rstN;

    logic        sclk0, csn0, mosi0, miso0, oe0;
    logic [15:0] txdata0, rxdata0;
    logic        txvalid0, txready0, rxvalid0, underrun0, busy0;

    logic        sclk3, csn3, mosi3, miso3, oe3;
    logic [7:0]  txdata3, rxdata3;
    logic        txvalid3, txready3, rxvalid3, underrun3, busy3;

    int          total;
    int          bad;

    logic [15:0] tx_tab0 [0:3];
    int          tx_n0, tx_base0, tx_idx0;
    logic [7:0]  tx_tab3 [0:3];
    int          tx_n3, tx_base3, tx_idx3;

    int          rx_cnt0, rdy_cnt0, und_cnt0;
    int          rx_cnt3, rdy_cnt3;
    logic [15:0] rx_hist0 [0:15];

    assign tx_idx0  = rdy_cnt0 - tx_base0;
    assign txvalid0 = (tx_idx0 < tx_n0);
    assign txdata0  = txvalid0 ? tx_tab0[tx_idx0[1:0]] : 16'h0000;
    assign tx_idx3  = rdy_cnt3 - tx_base3;
    assign txvalid3 = (tx_idx3 < tx_n3);
    assign txdata3  = txvalid3 ? tx_tab3[tx_idx3[1:0]] : 8'h00;

    spi_responder #(.DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) dut0 (
        .clkIn(clk), .rstN(rstN), .sclkIn(sclk0), .csNIn(csn0), .mosiIn(mosi0),
        .misoOut(miso0), .misoOe(oe0), .txData(txdata0), .txValid(txvalid0),
        .txReady(txready0), .rxData(rxdata0), .rxValid(rxvalid0),
        .txUnderrun(underrun0), .busy(busy0)
    );

    spi_responder #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) dut3 (
        .clkIn(clk), .rstN(rstN), .sclkIn(sclk3), .csNIn(csn3), .mosiIn(mosi3),
        .misoOut(miso3), .misoOe(oe3), .txData(txdata3), .txValid(txvalid3),
        .txReady(txready3), .rxData(rxdata3), .rxValid(rxvalid3),
        .txUnderrun(underrun3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and receive history, sampled away from the active edge
    initial begin
        rx_cnt0 = 0; rdy_cnt0 = 0; und_cnt0 = 0; rx_cnt3 = 0; rdy_cnt3 = 0;
    end
    always @(negedge clk) begin
        if (rxvalid0) begin
            rx_hist0[rx_cnt0[3:0]] <= rxdata0;
            rx_cnt0 <= rx_cnt0 + 1;
        end
        if (txready0)  rdy_cnt0 <= rdy_cnt0 + 1;
        if (underrun0) und_cnt0 <= und_cnt0 + 1;
        if (rxvalid3)  rx_cnt3  <= rx_cnt3 + 1;
        if (txready3)  rdy_cnt3 <= rdy_cnt3 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode-0 master: MISO read just before the rising (leading) edge
    task automatic xfer0(input logic [15:0] w, input int nbits, input bit last,
                         output logic [15:0] r);
        r = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            mosi0 = w[15-i];
            wait_cyc(PH);
            r = {r[14:0], miso0};
            sclk0 = 1'b1;
            if (last && (i == nbits - 1)) csn0 = 1'b1;
            wait_cyc(PH);
            sclk0 = 1'b0;
        end
    endtask

    task automatic frame0(input logic [15:0] w, output logic [15:0] r);
        csn0 = 1'b0;
        wait_cyc(PH);
        xfer0(w, 16, 1'b1, r);
        wait_cyc(PH);
    endtask

    // Mode-3 master: drive on falling edge, read MISO before the rising edge
    task automatic frame3(input logic [7:0] w, output logic [7:0] r);
        r = 8'h00;
        csn3 = 1'b0;
        wait_cyc(PH);
        for (int i = 0; i < 8; i++) begin
            sclk3 = 1'b0;
            mosi3 = w[7-i];
            wait_cyc(PH);
            r = {r[6:0], miso3};
            sclk3 = 1'b1;
            wait_cyc(PH);
        end
        csn3 = 1'b1;
        wait_cyc(PH);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_miso"},  32'(miso0), 32'h0);
        check({tag, "_oe"},    32'(oe0), 32'h0);
        check({tag, "_rxdata"}, 32'(rxdata0), 32'h0);
        check({tag, "_rxvalid"}, 32'(rxvalid0), 32'h0);
        check({tag, "_txready"}, 32'(txready0), 32'h0);
        check({tag, "_underrun"}, 32'(underrun0), 32'h0);
        check({tag, "_busy"},  32'(busy0), 32'h0);
    endtask

    logic [15:0] r0, r1;
    logic [7:0]  r3;
    int          rc, rd, uc;

    initial begin
        total = 0; bad = 0;
        rstN = 1'b0;
        sclk0 = 1'b0; csn0 = 1'b1; mosi0 = 1'b0;
        sclk3 = 1'b1; csn3 = 1'b1; mosi3 = 1'b0;
        tx_n0 = 0; tx_base0 = 0; tx_n3 = 0; tx_base3 = 0;
        for (int i = 0; i < 4; i++) begin
            tx_tab0[i] = 16'h0000;
            tx_tab3[i] = 8'h00;
        end

        wait_cyc(3);
        check_zero_outputs("reset");
        check("reset_rxdata3", 32'(rxdata3), 32'h0);
        rstN = 1'b1;
        wait_cyc(10);

        // Single word, mode 0
        tx_tab0[0] = 16'hA55A; tx_base0 = rdy_cnt0; tx_n0 = 1;
        rc = rx_cnt0; rd = rdy_cnt0; uc = und_cnt0;
        frame0(16'h3C96, r0);
        check("w1_rxcnt", 32'(rx_cnt0 - rc), 32'd1);
        check("w1_rxdata", 32'(rxdata0), 32'h3C96);
        check("w1_miso", 32'(r0), 32'hA55A);
        check("w1_txready", 32'(rdy_cnt0 - rd), 32'd1);
        check("w1_underrun", 32'(und_cnt0 - uc), 32'd0);
        check("w1_busy_idle", 32'(busy0), 32'h0);
        check("w1_oe_idle", 32'(oe0), 32'h0);

        // Back-to-back words in one frame
        tx_tab0[0] = 16'h1234; tx_tab0[1] = 16'h5678; tx_base0 = rdy_cnt0; tx_n0 = 2;
        rc = rx_cnt0; rd = rdy_cnt0; uc = und_cnt0;
        csn0 = 1'b0;
        wait_cyc(PH);
        xfer0(16'h0001, 16, 1'b0, r0);
        xfer0(16'hFFFE, 16, 1'b1, r1);
        wait_cyc(PH);
        check("b2b_rxcnt", 32'(rx_cnt0 - rc), 32'd2);
        check("b2b_rx0", 32'(rx_hist0[rc[3:0]]), 32'h0001);
        check("b2b_rx1", 32'(rx_hist0[4'(rc + 1)]), 32'hFFFE);
        check("b2b_miso0", 32'(r0), 32'h1234);
        check("b2b_miso1", 32'(r1), 32'h5678);
        check("b2b_txready", 32'(rdy_cnt0 - rd), 32'd2);
        check("b2b_underrun", 32'(und_cnt0 - uc), 32'd0);

        // Underrun: nothing offered at CS fall
        tx_base0 = rdy_cnt0; tx_n0 = 0;
        rc = rx_cnt0; rd = rdy_cnt0; uc = und_cnt0;
        frame0(16'h00FF, r0);
        check("und_pulses", 32'(und_cnt0 - uc), 32'd1);
        check("und_miso", 32'(r0), 32'h0000);
        check("und_rxdata", 32'(rxdata0), 32'h00FF);
        check("und_txready", 32'(rdy_cnt0 - rd), 32'd0);

        // Abort after 9 bits, then a clean frame
        tx_tab0[0] = 16'h9999; tx_base0 = rdy_cnt0; tx_n0 = 1;
        rc = rx_cnt0; rd = rdy_cnt0;
        csn0 = 1'b0;
        wait_cyc(PH);
        xfer0(16'hF0F0, 9, 1'b0, r0);
        wait_cyc(5);
        check("abort_busy_mid", 32'(busy0), 32'h1);
        check("abort_oe_mid", 32'(oe0), 32'h1);
        csn0 = 1'b1;
        wait_cyc(10);
        check("abort_busy", 32'(busy0), 32'h0);
        check("abort_oe", 32'(oe0), 32'h0);
        check("abort_miso", 32'(miso0), 32'h0);
        check("abort_rxcnt", 32'(rx_cnt0 - rc), 32'd0);
        check("abort_rxdata", 32'(rxdata0), 32'h00FF);
        check("abort_txready", 32'(rdy_cnt0 - rd), 32'd1);
        tx_tab0[0] = 16'hC0DE; tx_base0 = rdy_cnt0; tx_n0 = 1;
        rc = rx_cnt0;
        frame0(16'h5AC3, r0);
        check("post_abort_rxcnt", 32'(rx_cnt0 - rc), 32'd1);
        check("post_abort_rxdata", 32'(rxdata0), 32'h5AC3);
        check("post_abort_miso", 32'(r0), 32'hC0DE);

        // Reset mid-word at bit 5
        tx_tab0[0] = 16'h7777; tx_base0 = rdy_cnt0; tx_n0 = 1;
        rc = rx_cnt0;
        csn0 = 1'b0;
        wait_cyc(PH);
        xfer0(16'h1234, 5, 1'b0, r0);
        wait_cyc(5);
        check("rst_busy_before", 32'(busy0), 32'h1);
        #2 rstN = 1'b0;
        #1 check_zero_outputs("midrst");
        csn0 = 1'b1;
        wait_cyc(5);
        rstN = 1'b1;
        wait_cyc(10);
        check("midrst_rxcnt", 32'(rx_cnt0 - rc), 32'd0);
        tx_tab0[0] = 16'h0F0F; tx_base0 = rdy_cnt0; tx_n0 = 1;
        rc = rx_cnt0;
        frame0(16'hBEEF, r0);
        check("post_rst_rxcnt", 32'(rx_cnt0 - rc), 32'd1);
        check("post_rst_rxdata", 32'(rxdata0), 32'hBEEF);
        check("post_rst_miso", 32'(r0), 32'h0F0F);

        // CPOL=1 CPHA=1, 8-bit instance
        tx_tab3[0] = 8'h5A; tx_base3 = rdy_cnt3; tx_n3 = 1;
        rc = rx_cnt3; rd = rdy_cnt3;
        frame3(8'hC3, r3);
        check("m3_rxcnt", 32'(rx_cnt3 - rc), 32'd1);
        check("m3_rxdata", 32'(rxdata3), 32'hC3);
        check("m3_miso", 32'(r3), 32'h5A);
        check("m3_txready", 32'(rdy_cnt3 - rd), 32'd1);
        check("m3_busy_idle", 32'(busy3), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI slave (responder) endpoint. It is the far end of the SPI link whose master clock comes from the board clock scaler.
- Oversamples external SCLK, CS_n and MOSI in the clkIn domain, detects SCLK edges, and shifts DATA_WIDTH-bit words in and out, MSB first.
- Received words go to the fabric as single-cycle valid pulses. Transmit words come from the fabric through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 16: bits per SPI word.
- CPOL, 0: SCLK idle level; the leading edge is the transition away from CPOL.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- SYNC_STAGES, 2: synchronizer flops on sclkIn, csNIn and mosiIn (minimum 2).

Ports:
- clkIn  input  1  system clock; all logic on rising edge.
- rstN  input  1  asynchronous active-low reset.
- sclkIn  input  1  SPI clock from master (asynchronous).
- csNIn  input  1  chip select from master, active low (asynchronous).
- mosiIn  input  1  master-out data (asynchronous).
- misoOut  output  1  slave-out data.
- misoOe  output  1  MISO output enable; high while the synchronized CS_n is low.
- txData  input  DATA_WIDTH  next word to transmit.
- txValid  input  1  txData is valid.
- txReady  output  1  one-cycle pulse; txData is consumed this cycle.
- rxData  output  DATA_WIDTH  last complete received word.
- rxValid  output  1  one-cycle pulse; rxData updated.
- txUnderrun  output  1  one-cycle pulse; a word started with txValid low, so zeros are sent.
- busy  output  1  high in ACTIVE state.

Behaviour:
- Reset (rstN low, asynchronous):
  - All outputs 0 (misoOut 0, misoOe 0, rxData 0).
  - Synchronizers load idle values: sclk = CPOL, csN = 1, mosi = 0.
  - Shift registers and bit counter cleared; state IDLE.
- Synchronization and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - One extra register on synchronized sclk gives rise/fall detect. Leading/trailing edges are derived from CPOL.
  - Csn falling/rising edges are detected the same way.
- Timing constraint: each SCLK high and low phase must last at least SYNC_STAGES+2 clkIn cycles. Behaviour outside this constraint is undefined; the bench does not violate it.
- State IDLE:
  - SCLK edges ignored; misoOe 0; misoOut 0.
  - On synchronized csN falling: go ACTIVE, bitCnt = 0, perform a word load.
- Word load (same cycle):
  - If txValid: txShift = txData and txReady pulses.
  - Else: txShift = 0 and txUnderrun pulses.
- State ACTIVE, CPHA = 0:
  - misoOut = txShift[MSB] from the load cycle onward.
  - Leading edge: rxShift = {rxShift[DATA_WIDTH-2:0], mosi_sync}; bitCnt++.
  - Trailing edge: txShift shifts left by 1.
- State ACTIVE, CPHA = 1:
  - Leading edge: misoOut is updated from txShift; shift occurs, except on the first leading edge of a word, which only drives the MSB.
  - Trailing edge: sample mosi; bitCnt++.
- Word complete (the sample that makes bitCnt reach DATA_WIDTH):
  - Next cycle: rxData = final rxShift and rxValid pulses for exactly one cycle.
  - bitCnt returns to 0 and a word load is performed for back-to-back words within one CS frame.
  - rxValid has no backpressure; the consumer must take it on the pulse.
- Word boundary (CPHA=0): the reloaded MSB must be on misoOut before the next leading edge; the timing constraint guarantees this.
- bitCnt width is $clog2(DATA_WIDTH+1). It never exceeds DATA_WIDTH and wraps to 0 only through a word-complete event.
- Synchronized csN rising in ACTIVE:
  - Abort: partial rxShift discarded, no rxValid, bitCnt = 0.
  - misoOe 0 next cycle, misoOut 0, go IDLE.
  - A loaded but unsent txShift is dropped; no second txReady.
- Simultaneous events:
  - csN rising in the same cycle as the final sample: the completed word is still delivered (rxValid pulses), then IDLE, with no reload.
  - csN rising in the same cycle as a non-final sample: abort wins.
- SCLK edges while csN is high are ignored. An SCLK glitch shorter than the timing constraint is undefined.
- Reset asserted mid-word: immediate return to reset values; no rxValid.

Test Plan:
- Mode 0, DATA_WIDTH=16, txData=16'hA55A with txValid=1; master sends 16'h3C96 with SCLK phase 20 clkIn. Required: rxValid one pulse with rxData=16'h3C96; MISO bits sampled by master = 16'hA55A; txReady exactly one pulse at CS fall.
- Back-to-back: two words 16'h0001, 16'hFFFE in one CS frame; tx words 16'h1234, 16'h5678 offered. Required: two rxValid pulses in order; master receives 16'h1234 then 16'h5678; two txReady pulses.
- Underrun: txValid=0 at CS fall; master sends 16'h00FF. Required: txUnderrun one pulse, MISO all zeros, rxData=16'h00FF.
- Abort: CS deasserted after 9 of 16 bits. Required: no rxValid, rxData keeps its previous value, busy drops, and the next full frame receives correctly.
- CPOL=1 CPHA=1 build, 8-bit: master sends 8'hC3, txData=8'h5A. Required: rxData=8'hC3, master reads 8'h5A.
- Reset asserted at bit 5: all outputs 0 immediately; after release, a fresh frame of 16'hBEEF is received correctly.
